ex2_ex3_pipe_reg: RTL and testbench
===================================

Name: ex2_ex3_pipe_reg

Overview:
- Pipeline register between EX2 and EX3 of the 5+ stage MIPS datapath.
- Captures EX2 results and control, and drives the EX3-side signals consumed by the EX2 forwarding unit: RegDst1Result_EX3 and RegWrite_EX3.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.
- Guarantees that bubbles and writes to $zero never trigger forwarding.

Parameters:
- DATA_WIDTH, 32, width of ALU result and store-data fields
- REG_ADDR_WIDTH, 5, width of destination register address
- PERF_CNT_WIDTH, 32, width of optional performance counters

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous, active-high reset
- Stall_EX3  input  1  hold current contents
- Flush_EX3  input  1  load a bubble
- Valid_EX2  input  1  EX2 holds a real instruction
- ALUResult_EX2  input  DATA_WIDTH  EX2 ALU result
- ReadData2_EX2  input  DATA_WIDTH  store data (rt)
- RegDst1Result_EX2  input  REG_ADDR_WIDTH  destination register
- RegWrite_EX2  input  1  writes register file
- MemRead_EX2  input  1  load
- MemWrite_EX2  input  1  store
- MemToReg_EX2  input  1  writeback selects memory data
- Valid_EX3  output  1  EX3 holds a real instruction
- ALUResult_EX3  output  DATA_WIDTH  registered ALU result
- ReadData2_EX3  output  DATA_WIDTH  registered store data
- RegDst1Result_EX3  output  REG_ADDR_WIDTH  registered destination
- RegWrite_EX3  output  1  qualified register write
- MemRead_EX3  output  1  qualified load
- MemWrite_EX3  output  1  qualified store
- MemToReg_EX3  output  1  registered writeback select
- StallCycles  output  PERF_CNT_WIDTH  only with PIPE_PERF_CNT_EN
- BubbleCount  output  PERF_CNT_WIDTH  only with PIPE_PERF_CNT_EN

Behaviour:
- All outputs are registered; latency is 1 cycle from EX2 inputs to EX3 outputs.
- Reset (Rst=1 at a rising edge): every output = 0, including Valid_EX3, RegDst1Result_EX3 and the counters. Reset overrides Stall and Flush and takes effect mid-stall.
- Per-edge priority: Rst > Flush_EX3 > Stall_EX3 > normal load.
- Normal load (no Rst, Flush or Stall):
  - Valid_EX3 <= Valid_EX2.
  - Data fields and RegDst1Result_EX3 copied unconditionally.
  - RegWrite_EX3 <= RegWrite_EX2 & Valid_EX2 & (RegDst1Result_EX2 != 0).
  - MemRead_EX3 <= MemRead_EX2 & Valid_EX2.
  - MemWrite_EX3 <= MemWrite_EX2 & Valid_EX2.
  - MemToReg_EX3 copied.
- Flush (bubble):
  - Valid_EX3, RegWrite_EX3, MemRead_EX3, MemWrite_EX3 and MemToReg_EX3 <= 0.
  - RegDst1Result_EX3 <= 0.
  - Data fields keep their previous values (don't-care, but not X).
  - Flush asserted together with Stall still produces a bubble.
- Stall: all registers hold. Multi-cycle stalls hold indefinitely. Releasing the stall loads the EX2 inputs presented in that cycle.
- Invariant: RegWrite_EX3=1 implies Valid_EX3=1 and RegDst1Result_EX3 != 0, so the downstream forwarding comparison never matches a bubble or $zero.
- MemRead_EX2 and MemWrite_EX2 both 1 is illegal upstream. Both are registered as given, with no arbitration.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - StallCycles increments on each edge with Stall_EX3=1, Flush_EX3=0, Rst=0.
  - BubbleCount increments on each edge where the loaded Valid_EX3 becomes 0, whether from flush or from Valid_EX2=0.
  - Both counters saturate at all-ones (no wrap) and clear on Rst.
- Not defined: StallCycles and BubbleCount ports are absent and no counter logic exists. All other behaviour is identical.

Test Plan:
- Reset: Rst=1 for 2 cycles with arbitrary inputs -> all outputs 0, Valid_EX3=0; first load after Rst deasserts appears 1 cycle later.
- Pass-through: Valid_EX2=1, ALUResult_EX2=0x0000_1234, RegDst1Result_EX2=8, RegWrite_EX2=1 -> next edge ALUResult_EX3=0x1234, RegDst1Result_EX3=8, RegWrite_EX3=1, Valid_EX3=1.
- $zero qualification: RegDst1Result_EX2=0, RegWrite_EX2=1, Valid_EX2=1 -> RegWrite_EX3=0, Valid_EX3=1.
- Stall: load dest=9, then Stall_EX3=1 for 3 cycles while inputs change to dest=10 -> outputs hold dest=9 for 3 cycles; dest=10 appears on the edge after Stall drops. With PIPE_PERF_CNT_EN, StallCycles=3.
- Flush beats stall: Stall_EX3=1 and Flush_EX3=1 with MemWrite_EX2=1, Valid_EX2=1 -> Valid_EX3=0, MemWrite_EX3=0, RegWrite_EX3=0, RegDst1Result_EX3=0. With PIPE_PERF_CNT_EN, BubbleCount=1.
- Reset mid-stall: Stall_EX3=1 holding dest=5, RegWrite=1; assert Rst for 1 cycle -> RegWrite_EX3=0, RegDst1Result_EX3=0, counters 0.

Source files
------------

// File: rtl/ex2_ex3_pipe_reg.sv
// ---------------------------------------------------------------------------
// ex2_ex3_pipe_reg
//
// Pipeline register between the EX2 and EX3 stages of the MIPS datapath.
// It captures the EX2 results and control, and drives the EX3-side
// destination/write-enable pair that the EX2 forwarding unit compares
// against. RegWrite_EX3 is qualified so that a bubble or a write to $zero
// can never produce a forwarding match.
//
// Optional feature: define PIPE_PERF_CNT_EN to add the StallCycles and
// BubbleCount saturating performance counters (and their width parameter).
//
// Ports
//   Clk, Rst            rising-edge clock, synchronous active-high reset
//   Stall_EX3           hold the current contents
//   Flush_EX3           load a bubble (takes priority over Stall_EX3)
//   *_EX2               EX2 result, store data, destination and control
//   *_EX3               registered EX3 copies (control fields qualified)
//   StallCycles         edges spent stalled (PIPE_PERF_CNT_EN only)
//   BubbleCount         edges that loaded a bubble (PIPE_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module ex2_ex3_pipe_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int PERF_CNT_WIDTH = 32
`endif
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Stall_EX3,
    input  logic                      Flush_EX3,
    input  logic                      Valid_EX2,
    input  logic [DATA_WIDTH-1:0]     ALUResult_EX2,
    input  logic [DATA_WIDTH-1:0]     ReadData2_EX2,
    input  logic [REG_ADDR_WIDTH-1:0] RegDst1Result_EX2,
    input  logic                      RegWrite_EX2,
    input  logic                      MemRead_EX2,
    input  logic                      MemWrite_EX2,
    input  logic                      MemToReg_EX2,
    output logic                      Valid_EX3,
    output logic [DATA_WIDTH-1:0]     ALUResult_EX3,
    output logic [DATA_WIDTH-1:0]     ReadData2_EX3,
    output logic [REG_ADDR_WIDTH-1:0] RegDst1Result_EX3,
    output logic                      RegWrite_EX3,
    output logic                      MemRead_EX3,
    output logic                      MemWrite_EX3,
    output logic                      MemToReg_EX3
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] StallCycles,
    output logic [PERF_CNT_WIDTH-1:0] BubbleCount
`endif
);

    // A write to $zero is architecturally discarded, so it must never look
    // like a forwardable producer to the EX2 forwarding unit.
    logic dest_nonzero;
    assign dest_nonzero = (RegDst1Result_EX2 != '0);

    // Priority per edge: reset, then flush, then stall (hold), then load.
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge values of its sources.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            // NOTE: the data fields are reset too; every EX3 output must
            // read as zero after reset, not just the control bits.
            Valid_EX3         <= 1'b0;
            ALUResult_EX3     <= '0;
            ReadData2_EX3     <= '0;
            RegDst1Result_EX3 <= '0;
            RegWrite_EX3      <= 1'b0;
            MemRead_EX3       <= 1'b0;
            MemWrite_EX3      <= 1'b0;
            MemToReg_EX3      <= 1'b0;
        end else if (Flush_EX3) begin
            // Bubble: kill every control bit and the destination. The data
            // fields are left as they were; they are don't-care in a bubble.
            Valid_EX3         <= 1'b0;
            RegDst1Result_EX3 <= '0;
            RegWrite_EX3      <= 1'b0;
            MemRead_EX3       <= 1'b0;
            MemWrite_EX3      <= 1'b0;
            MemToReg_EX3      <= 1'b0;
        end else if (!Stall_EX3) begin
            Valid_EX3         <= Valid_EX2;
            ALUResult_EX3     <= ALUResult_EX2;
            ReadData2_EX3     <= ReadData2_EX2;
            RegDst1Result_EX3 <= RegDst1Result_EX2;
            RegWrite_EX3      <= RegWrite_EX2 & Valid_EX2 & dest_nonzero;
            // Load and store are not arbitrated; both are passed as given.
            MemRead_EX3       <= MemRead_EX2 & Valid_EX2;
            MemWrite_EX3      <= MemWrite_EX2 & Valid_EX2;
            MemToReg_EX3      <= MemToReg_EX2;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // A stall edge only counts when it actually holds (a flush overrides it).
    // A bubble is any edge that loads Valid_EX3 = 0: a flush, or a normal
    // load of an invalid EX2 slot. Held stall edges load nothing.
    logic stall_event;
    logic bubble_event;
    assign stall_event  = Stall_EX3 & ~Flush_EX3;
    assign bubble_event = Flush_EX3 | (~Stall_EX3 & ~Valid_EX2);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            StallCycles <= '0;
            BubbleCount <= '0;
        end else begin
            // Both counters saturate at all-ones instead of wrapping.
            if (stall_event && (StallCycles != '1))
                StallCycles <= StallCycles + PERF_CNT_WIDTH'(1);
            if (bubble_event && (BubbleCount != '1))
                BubbleCount <= BubbleCount + PERF_CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ex2_ex3_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_ex2_ex3_pipe_reg
//
// Self-checking bench for ex2_ex3_pipe_reg: directed steps from the test
// plan followed by a randomized phase, all compared against a behavioural
// model of what the EX3 stage should hold. The counters are narrowed to
// 4 bits so saturation is reached in the random phase.
// ---------------------------------------------------------------------------
module tb_ex2_ex3_pipe_reg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          flush;
    logic          valid_ex2;
    logic [DW-1:0] alu_ex2;
    logic [DW-1:0] rd2_ex2;
    logic [AW-1:0] dest_ex2;
    logic          rw_ex2;
    logic          mr_ex2;
    logic          mw_ex2;
    logic          m2r_ex2;

    logic          valid_ex3;
    logic [DW-1:0] alu_ex3;
    logic [DW-1:0] rd2_ex3;
    logic [AW-1:0] dest_ex3;
    logic          rw_ex3;
    logic          mr_ex3;
    logic          mw_ex3;
    logic          m2r_ex3;
`ifdef PIPE_PERF_CNT_EN
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] bubble_count;
`endif

    ex2_ex3_pipe_reg #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (AW)
`ifdef PIPE_PERF_CNT_EN
        ,
        .PERF_CNT_WIDTH (CW)
`endif
    ) dut (
        .Clk               (clk),
        .Rst               (rst),
        .Stall_EX3         (stall),
        .Flush_EX3         (flush),
        .Valid_EX2         (valid_ex2),
        .ALUResult_EX2     (alu_ex2),
        .ReadData2_EX2     (rd2_ex2),
        .RegDst1Result_EX2 (dest_ex2),
        .RegWrite_EX2      (rw_ex2),
        .MemRead_EX2       (mr_ex2),
        .MemWrite_EX2      (mw_ex2),
        .MemToReg_EX2      (m2r_ex2),
        .Valid_EX3         (valid_ex3),
        .ALUResult_EX3     (alu_ex3),
        .ReadData2_EX3     (rd2_ex3),
        .RegDst1Result_EX3 (dest_ex3),
        .RegWrite_EX3      (rw_ex3),
        .MemRead_EX3       (mr_ex3),
        .MemWrite_EX3      (mw_ex3),
        .MemToReg_EX3      (m2r_ex3)
`ifdef PIPE_PERF_CNT_EN
        ,
        .StallCycles       (stall_cycles),
        .BubbleCount       (bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What the EX3 stage is expected to hold, as an instruction record.
    typedef struct {
        logic          valid;
        logic [DW-1:0] alu;
        logic [DW-1:0] rd2;
        logic [AW-1:0] dest;
        logic          rw;
        logic          mr;
        logic          mw;
        logic          m2r;
    } ex3_t;

    ex3_t exp_ex3;
    int   n_stall_edges;
    int   n_bubble_edges;
    int   vectors;
    int   miscompares;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int sat(input int n);
        int lim;
        lim = (1 << CW) - 1;
        return (n > lim) ? lim : n;
    endfunction

    // Reference model: what one rising edge does to the EX3 record.
    task automatic model_edge();
        ex3_t bubble;
        bubble       = exp_ex3;
        bubble.valid = 1'b0;
        bubble.dest  = '0;
        bubble.rw    = 1'b0;
        bubble.mr    = 1'b0;
        bubble.mw    = 1'b0;
        bubble.m2r   = 1'b0;
        if (rst) begin
            exp_ex3        = '{1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0};
            n_stall_edges  = 0;
            n_bubble_edges = 0;
        end else if (flush) begin
            exp_ex3 = bubble;
            n_bubble_edges++;
        end else if (stall) begin
            n_stall_edges++;
        end else begin
            // A real instruction only writes when it targets a non-$zero reg.
            exp_ex3.valid = valid_ex2;
            exp_ex3.alu   = alu_ex2;
            exp_ex3.rd2   = rd2_ex2;
            exp_ex3.dest  = dest_ex2;
            exp_ex3.rw    = valid_ex2 && rw_ex2 && (dest_ex2 != 0);
            exp_ex3.mr    = valid_ex2 && mr_ex2;
            exp_ex3.mw    = valid_ex2 && mw_ex2;
            exp_ex3.m2r   = m2r_ex2;
            if (!valid_ex2) n_bubble_edges++;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, 64'(valid_ex3), 64'(exp_ex3.valid));
        check({tag, ".alu"},   64'(alu_ex3),   64'(exp_ex3.alu));
        check({tag, ".rd2"},   64'(rd2_ex3),   64'(exp_ex3.rd2));
        check({tag, ".dest"},  64'(dest_ex3),  64'(exp_ex3.dest));
        check({tag, ".rw"},    64'(rw_ex3),    64'(exp_ex3.rw));
        check({tag, ".mr"},    64'(mr_ex3),    64'(exp_ex3.mr));
        check({tag, ".mw"},    64'(mw_ex3),    64'(exp_ex3.mw));
        check({tag, ".m2r"},   64'(m2r_ex3),   64'(exp_ex3.m2r));
`ifdef PIPE_PERF_CNT_EN
        check({tag, ".stall_cnt"},  64'(stall_cycles), 64'(sat(n_stall_edges)));
        check({tag, ".bubble_cnt"}, 64'(bubble_count), 64'(sat(n_bubble_edges)));
`endif
    endtask

    // One clock: model and DUT see the same edge, outputs sampled 1 later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] alu,
                         input logic [AW-1:0] dest, input logic rw,
                         input logic mr, input logic mw, input logic m2r);
        valid_ex2 = v;
        alu_ex2   = alu;
        rd2_ex2   = $urandom;
        dest_ex2  = dest;
        rw_ex2    = rw;
        mr_ex2    = mr;
        mw_ex2    = mw;
        m2r_ex2   = m2r;
    endtask

    task automatic drive_random();
        drive(1'($urandom), $urandom, AW'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        n_stall_edges  = 0;
        n_bubble_edges = 0;
        exp_ex3        = '{1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0};
        rst   = 1'b1;
        stall = 1'($urandom);
        flush = 1'($urandom);
        drive_random();

        // Reset for two cycles with arbitrary inputs.
        step("reset0");
        drive_random();
        stall = 1'($urandom);
        step("reset1");
        check("reset.valid_zero", 64'(valid_ex3), 64'd0);
        check("reset.alu_zero",   64'(alu_ex3),   64'd0);

        // Pass-through: first load lands one edge after reset drops.
        rst   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 32'h0000_1234, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        step("pass");
        check("pass.alu_const",  64'(alu_ex3),   64'h1234);
        check("pass.dest_const", 64'(dest_ex3),  64'd8);
        check("pass.rw_const",   64'(rw_ex3),    64'd1);

        // A write to $zero stays valid but never writes.
        drive(1'b1, $urandom, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("zero");
        check("zero.rw_const",    64'(rw_ex3),    64'd0);
        check("zero.valid_const", 64'(valid_ex3), 64'd1);

        // Stall: hold dest=9 for three edges while dest=10 waits.
        rst = 1'b1;
        step("stall_rst");
        rst = 1'b0;
        drive(1'b1, $urandom, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        step("stall_load");
        stall = 1'b1;
        drive(1'b1, $urandom, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold");
            check("stall.dest_held", 64'(dest_ex3), 64'd9);
        end
        stall = 1'b0;
        step("stall_release");
        check("stall.dest_new", 64'(dest_ex3), 64'd10);
`ifdef PIPE_PERF_CNT_EN
        check("stall.cnt_const", 64'(stall_cycles), 64'd3);
`endif

        // Flush together with stall still inserts a bubble.
        stall = 1'b1;
        flush = 1'b1;
        drive(1'b1, $urandom, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1);
        step("flush");
        check("flush.valid_const", 64'(valid_ex3), 64'd0);
        check("flush.mw_const",    64'(mw_ex3),    64'd0);
        check("flush.rw_const",    64'(rw_ex3),    64'd0);
        check("flush.dest_const",  64'(dest_ex3),  64'd0);
`ifdef PIPE_PERF_CNT_EN
        check("flush.bubble_const", 64'(bubble_count), 64'd1);
`endif

        // Reset arriving in the middle of a stall.
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, $urandom, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("midrst_load");
        stall = 1'b1;
        step("midrst_hold");
        rst = 1'b1;
        step("midrst_rst");
        check("midrst.rw_const",   64'(rw_ex3),   64'd0);
        check("midrst.dest_const", 64'(dest_ex3), 64'd0);
`ifdef PIPE_PERF_CNT_EN
        check("midrst.stall_cnt_const",  64'(stall_cycles), 64'd0);
        check("midrst.bubble_cnt_const", 64'(bubble_count), 64'd0);
`endif
        rst   = 1'b0;
        stall = 1'b0;

        // Randomized traffic with occasional stalls, flushes and resets.
        for (int i = 0; i < 400; i++) begin
            drive_random();
            rst   = ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 9) < 2);
            step("rand");
            check("rand.fwd_invariant",
                  64'(!rw_ex3 || (valid_ex3 && dest_ex3 != 0)), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
